// File: rtl/dram_arbiter_pkg.sv
// Shared encodings for the DRAM arbiter: FSM states and one-hot grant values.
package dram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/dram_arb_pick.sv
// Combinational pick between two requesters; tie rule selected by DRAM_ARBITER_FIXED_PRIO_EN
// (defined: m0 always wins ties; undefined: the master not served last wins ties).
module dram_arb_pick
    import dram_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] grant
);

`ifdef DRAM_ARBITER_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
    logic tie_pick;
    assign tie_pick = 1'b0;
`else
    logic tie_pick;
    assign tie_pick = ~last;
`endif

    always_comb begin
        grant = GRANT_NONE;
        if (req0 && req1) begin
            grant = tie_pick ? GRANT_M1 : GRANT_M0;
        end else if (req0) begin
            grant = GRANT_M0;
        end else if (req1) begin
            grant = GRANT_M1;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Two-master DRAM port arbiter: grants whole transactions and routes completions to the owner.
// Tie policy comes from dram_arb_pick (DRAM_ARBITER_FIXED_PRIO_EN selects fixed priority).
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_data_out,
    input  logic              m0_req_read,
    input  logic              m0_req_write,
    output logic [DATA_W-1:0] m0_data_in,
    output logic              m0_data_valid,
    output logic              m0_write_complete,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_data_out,
    input  logic              m1_req_read,
    input  logic              m1_req_write,
    output logic [DATA_W-1:0] m1_data_in,
    output logic              m1_data_valid,
    output logic              m1_write_complete,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_data_out,
    output logic              dram_req_read,
    output logic              dram_req_write,
    input  logic [DATA_W-1:0] dram_data_in,
    input  logic              dram_data_valid,
    input  logic              dram_write_complete,
    output logic [1:0]        grant
);

    // Handshake: a master holds its level request until the matching completion pulse;
    // the DRAM request is held until the controller pulses the completion of the issued type.
    arb_state_t        state, state_next;
    logic              last, last_next;
    logic [1:0]        grant_next, pick_grant;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;
    logic              rd_next, wr_next;
    logic              sel, busy, done;

    dram_arb_pick u_pick (
        .req0  (m0_req_read | m0_req_write),
        .req1  (m1_req_read | m1_req_write),
        .last  (last),
        .grant (pick_grant)
    );

    assign busy = (state == ARB_BUSY);
    assign done = busy && ((dram_req_read && dram_data_valid) ||
                           (dram_req_write && dram_write_complete));
    assign sel  = pick_grant[1];

    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last;
        addr_next  = dram_addr;
        data_next  = dram_data_out;
        rd_next    = dram_req_read;
        wr_next    = dram_req_write;
        case (state)
            ARB_IDLE: begin
                if (pick_grant != GRANT_NONE) begin
                    addr_next  = sel ? m1_addr : m0_addr;
                    data_next  = sel ? m1_data_out : m0_data_out;
                    // A simultaneous read+write is serviced as a read only.
                    rd_next    = sel ? m1_req_read : m0_req_read;
                    wr_next    = sel ? (m1_req_write & ~m1_req_read)
                                     : (m0_req_write & ~m0_req_read);
                    grant_next = pick_grant;
                    last_next  = sel;
                    state_next = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (done) begin
                    rd_next    = 1'b0;
                    wr_next    = 1'b0;
                    grant_next = GRANT_NONE;
                    state_next = ARB_RELEASE;
                end
            end
            ARB_RELEASE: state_next = ARB_IDLE;
            default:     state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ARB_IDLE;
            grant          <= GRANT_NONE;
            last           <= 1'b1;
            dram_addr      <= '0;
            dram_data_out  <= '0;
            dram_req_read  <= 1'b0;
            dram_req_write <= 1'b0;
        end else begin
            state          <= state_next;
            grant          <= grant_next;
            last           <= last_next;
            dram_addr      <= addr_next;
            dram_data_out  <= data_next;
            dram_req_read  <= rd_next;
            dram_req_write <= wr_next;
        end
    end

    // Completions of the wrong type, or outside BUSY, never reach a master.
    always_comb begin
        m0_data_in        = '0;
        m1_data_in        = '0;
        m0_data_valid     = 1'b0;
        m1_data_valid     = 1'b0;
        m0_write_complete = 1'b0;
        m1_write_complete = 1'b0;
        if (busy && grant[0]) begin
            m0_data_in        = dram_data_in;
            m0_data_valid     = dram_req_read & dram_data_valid;
            m0_write_complete = dram_req_write & dram_write_complete;
        end
        if (busy && grant[1]) begin
            m1_data_in        = dram_data_in;
            m1_data_valid     = dram_req_read & dram_data_valid;
            m1_write_complete = dram_req_write & dram_write_complete;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dram_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_data_out, m1_data_out;
    logic              m0_req_read, m0_req_write, m1_req_read, m1_req_write;
    logic [DATA_W-1:0] m0_data_in, m1_data_in;
    logic              m0_data_valid, m0_write_complete, m1_data_valid, m1_write_complete;
    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_data_out;
    logic              dram_req_read, dram_req_write;
    logic [DATA_W-1:0] dram_data_in;
    logic              dram_data_valid, dram_write_complete;
    logic [1:0]        grant;

    always #5 clk = ~clk;

    dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_data_out(m0_data_out),
        .m0_req_read(m0_req_read), .m0_req_write(m0_req_write),
        .m0_data_in(m0_data_in), .m0_data_valid(m0_data_valid),
        .m0_write_complete(m0_write_complete),
        .m1_addr(m1_addr), .m1_data_out(m1_data_out),
        .m1_req_read(m1_req_read), .m1_req_write(m1_req_write),
        .m1_data_in(m1_data_in), .m1_data_valid(m1_data_valid),
        .m1_write_complete(m1_write_complete),
        .dram_addr(dram_addr), .dram_data_out(dram_data_out),
        .dram_req_read(dram_req_read), .dram_req_write(dram_req_write),
        .dram_data_in(dram_data_in), .dram_data_valid(dram_data_valid),
        .dram_write_complete(dram_write_complete), .grant(grant)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: the one transaction in flight, plus a release gap.
    bit                md_busy, md_rd, md_rel;
    int                md_owner, md_last;
    logic [ADDR_W-1:0] md_addr;
    logic [DATA_W-1:0] md_data;
    bit                done0, done1;

    bit         track_order;
    logic [1:0] prev_grant;
    logic [1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        bit own0, own1;
        own0 = md_busy && md_owner == 0;
        own1 = md_busy && md_owner == 1;
        check("grant", 64'(grant), 64'({own1, own0}));
        check("dram_req_read", 64'(dram_req_read), 64'(md_busy && md_rd));
        check("dram_req_write", 64'(dram_req_write), 64'(md_busy && !md_rd));
        check("dram_addr", 64'(dram_addr), 64'(md_addr));
        check("dram_data_out", 64'(dram_data_out), 64'(md_data));
        check("m0_data_in", 64'(m0_data_in), own0 ? 64'(dram_data_in) : 64'd0);
        check("m1_data_in", 64'(m1_data_in), own1 ? 64'(dram_data_in) : 64'd0);
        check("m0_data_valid", 64'(m0_data_valid), 64'(own0 && md_rd && dram_data_valid));
        check("m1_data_valid", 64'(m1_data_valid), 64'(own1 && md_rd && dram_data_valid));
        check("m0_write_complete", 64'(m0_write_complete),
              64'(own0 && !md_rd && dram_write_complete));
        check("m1_write_complete", 64'(m1_write_complete),
              64'(own1 && !md_rd && dram_write_complete));
        done0 = own0 && (md_rd ? dram_data_valid : dram_write_complete);
        done1 = own1 && (md_rd ? dram_data_valid : dram_write_complete);
    endtask

    task automatic model_advance();
        bit r0, r1;
        int w;
        r0 = m0_req_read || m0_req_write;
        r1 = m1_req_read || m1_req_write;
        if (!rst_n) begin
            md_busy = 0; md_rel = 0; md_last = 1;
            md_addr = '0; md_data = '0;
        end else if (md_busy) begin
            if (md_rd ? dram_data_valid : dram_write_complete) begin
                md_busy = 0;
                md_rel  = 1;
            end
        end else if (md_rel) begin
            md_rel = 0;
        end else if (r0 || r1) begin
            if (r0 && r1) begin
`ifdef DRAM_ARBITER_FIXED_PRIO_EN
                w = 0;
`else
                w = 1 - md_last;
`endif
            end else begin
                w = r0 ? 0 : 1;
            end
            md_owner = w;
            md_last  = w;
            md_busy  = 1;
            md_rd    = (w == 1) ? m1_req_read : m0_req_read;
            md_addr  = (w == 1) ? m1_addr : m0_addr;
            md_data  = (w == 1) ? m1_data_out : m0_data_out;
        end
    endtask

    // One clock: inputs are already set after the falling edge.
    task automatic step();
        #1;
        check_outputs();
        if (track_order && grant != 2'b00 && prev_grant == 2'b00) begin
            if (exp_q.size() > 0) check("order", 64'(grant), 64'(exp_q.pop_front()));
        end
        prev_grant = grant;
        model_advance();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_req_read = 0; m0_req_write = 0; m1_req_read = 0; m1_req_write = 0;
        dram_data_valid = 0; dram_write_complete = 0;
    endtask

    task automatic resp_auto();
        dram_data_valid     = md_busy && md_rd;
        dram_write_complete = md_busy && !md_rd;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            m0_req_read = 0; m0_req_write = 0; m1_req_read = 0; m1_req_write = 0;
            resp_auto();
            step();
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 0;
        m0_addr = '0; m1_addr = '0; m0_data_out = '0; m1_data_out = '0;
        dram_data_in = '0;
        clear_inputs();
        track_order = 0; prev_grant = 2'b00;
        md_busy = 0; md_rel = 0; md_last = 1; md_owner = 0; md_rd = 0;
        md_addr = '0; md_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held with a pending m0 read, then released.
        m0_req_read = 1;
        m0_addr = 24'h00_0042;
        for (int i = 0; i < 3; i++) begin
            #1 check("t1_reset_grant", 64'(grant), 64'd0);
            check("t1_reset_req", 64'({dram_req_read, dram_req_write}), 64'd0);
            step();
        end
        rst_n = 1;
        step();
        #1 check("t1_grant", 64'(grant), 64'(2'b01));
        check("t1_req_read", 64'(dram_req_read), 64'd1);
        dram_data_valid = 1;
        step();
        clear_inputs();
        step(); step();

        // m1 write.
        m1_req_write = 1; m1_addr = 24'h00_1234; m1_data_out = 32'hDEADBEEF;
        step();
        #1 check("t2_addr", 64'(dram_addr), 64'h1234);
        check("t2_data", 64'(dram_data_out), 64'hDEADBEEF);
        check("t2_req_write", 64'(dram_req_write), 64'd1);
        check("t2_grant", 64'(grant), 64'(2'b10));
        step();
        dram_write_complete = 1;
        #1 check("t2_wc1", 64'(m1_write_complete), 64'd1);
        check("t2_wc0", 64'(m0_write_complete), 64'd0);
        step();
        clear_inputs();
        #1 check("t2_wc1_off", 64'(m1_write_complete), 64'd0);
        check("t2_req_write_off", 64'(dram_req_write), 64'd0);
        step(); step();

        // m0 read data return, then exactly one RELEASE cycle.
        m0_req_read = 1; m0_addr = 24'h00_0777;
        step();
        dram_data_in = 32'hCAFEF00D; dram_data_valid = 1;
        #1 check("t4_m0_data", 64'(m0_data_in), 64'hCAFEF00D);
        check("t4_m1_data", 64'(m1_data_in), 64'd0);
        check("t4_valid", 64'(m0_data_valid), 64'd1);
        step();
        clear_inputs();
        m1_req_read = 1;
        #1 check("t4_req_read_off", 64'(dram_req_read), 64'd0);
        check("t4_release_grant", 64'(grant), 64'd0);
        step();
        #1 check("t4_idle_grant", 64'(grant), 64'd0);
        step();
        #1 check("t4_m1_granted", 64'(grant), 64'(2'b10));
        drain(4);

        // Wrong-type and idle completions are dropped.
        m0_req_write = 1; m0_addr = 24'h00_0900; m0_data_out = 32'h1111_2222;
        step();
        dram_data_valid = 1;
        #1 check("t5_no_valid", 64'(m0_data_valid), 64'd0);
        step();
        dram_data_valid = 0;
        #1 check("t5_still_busy", 64'(grant), 64'(2'b01));
        dram_write_complete = 1;
        step();
        clear_inputs();
        step(); step();
        dram_data_valid = 1; dram_write_complete = 1;
        #1 check("t5_idle_valid", 64'({m0_data_valid, m1_data_valid}), 64'd0);
        check("t5_idle_wc", 64'({m0_write_complete, m1_write_complete}), 64'd0);
        step();
        clear_inputs();
        #1 check("t5_idle_grant", 64'(grant), 64'd0);
        step();

        // Reset during BUSY, then a late completion.
        m1_req_read = 1; m1_addr = 24'h00_0ABC;
        step();
        rst_n = 0;
        step();
        #1 check("t6_req_drop", 64'({dram_req_read, dram_req_write}), 64'd0);
        check("t6_grant", 64'(grant), 64'd0);
        m1_req_read = 0; rst_n = 1; dram_data_valid = 1;
        #1 check("t6_late_valid", 64'({m0_data_valid, m1_data_valid}), 64'd0);
        step();
        clear_inputs();
        step();

        // Both masters holding reads: grant order.
`ifdef DRAM_ARBITER_FIXED_PRIO_EN
        exp_q = '{2'b01, 2'b01, 2'b01};
`else
        exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        track_order = 1;
        m0_req_read = 1; m1_req_read = 1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            resp_auto();
            step();
        end
        track_order = 0;
        check("t3_order_done", 64'(exp_q.size()), 64'd0);
        drain(6);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if (done0) begin
                m0_req_read = 0; m0_req_write = 0;
            end else if (!(m0_req_read || m0_req_write) && $urandom_range(0, 3) == 0) begin
                int t;
                t = $urandom_range(0, 9);
                m0_req_read = (t <= 5); m0_req_write = (t == 0) || (t > 5);
                m0_addr = ADDR_W'($urandom); m0_data_out = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                m0_addr = ADDR_W'($urandom); m0_data_out = $urandom;
            end
            if (done1) begin
                m1_req_read = 0; m1_req_write = 0;
            end else if (!(m1_req_read || m1_req_write) && $urandom_range(0, 3) == 0) begin
                int t;
                t = $urandom_range(0, 9);
                m1_req_read = (t <= 5); m1_req_write = (t == 0) || (t > 5);
                m1_addr = ADDR_W'($urandom); m1_data_out = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                m1_addr = ADDR_W'($urandom); m1_data_out = $urandom;
            end
            dram_data_in = $urandom;
            dram_data_valid = 0; dram_write_complete = 0;
            if (md_busy && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    dram_data_valid = !md_rd; dram_write_complete = md_rd;
                end else begin
                    dram_data_valid = md_rd; dram_write_complete = !md_rd;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                dram_data_valid = 1'($urandom); dram_write_complete = 1'($urandom);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
